instr_fetch_unit: RTL and testbench

Upstream neighbour of the RV32I pipeline core: replaces the combinational PC/instruction_memory pair with a decoupled fetch stage. Issues word fetches over a valid/ready request channel and accepts in-order responses. Buffers fetched instructions with their PCs in a small FIFO, and presents them to IF/ID through a valid/ready handshake. A redirect (taken branch/jump) flushes the buffer and discards stale in-flight responses.

---
 rtl/rv_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the decoupled instruction fetch stage.
package rv_fetch_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Non-bypassing DEPTH-entry FIFO of {instr, pc} with synchronous flush.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] wr_instr,
    input  logic [XLEN-1:0] wr_pc,
    output logic [XLEN-1:0] rd_instr,
    output logic [XLEN-1:0] rd_pc,
    output logic [CW-1:0]   occupancy
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push, do_pop;

    // A clear voids any push or pop issued in the same cycle.
    assign do_push = push && !clear;
    assign do_pop  = pop && (cnt_q != '0) && !clear;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= '{instr: wr_instr, pc: wr_pc};
    end

    assign rd_instr  = mem_q[rd_ptr_q].instr;
    assign rd_pc     = mem_q[rd_ptr_q].pc;
    assign occupancy = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: issues word requests, buffers in-order responses, flushes on redirect.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fault/HALT on misaligned redirect targets.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fault,
`endif
    output logic        busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d, disc_q, disc_d, occ;
    logic [XLEN-1:0] head_instr, head_pc;
    logic            fire, rsp_ok, push, pop;

    assign fire   = mem_req_valid && mem_req_ready;
    assign rsp_ok = mem_rsp_valid && (out_q != '0);
    assign push   = rsp_ok && (disc_q == '0) && !redirect;
    assign pop    = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = FETCH;
            // Leaving FETCH must not retract a request already on the bus.
            FETCH:   if (!enable && !(mem_req_valid && !mem_req_ready)) state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (redirect && state_q != HALT) state_d = enable ? FETCH : IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect && redirect_pc[1:0] != 2'b00) state_d = HALT;
`endif
    end

    always_comb begin
        mem_req_valid = 1'b0;
        if (state_q == FETCH)
            mem_req_valid = ({1'b0, occ} + {1'b0, out_q} < SW'(DEPTH)) &&
                            (out_q < CW'(MAX_OUTSTANDING));
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        disc_d     = disc_q;
        out_d      = out_q + CW'(fire) - CW'(rsp_ok);
        if (fire)                      fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)                      rsp_pc_d   = rsp_pc_q + 32'd4;
        if (rsp_ok && disc_q != '0)    disc_d     = disc_q - CW'(1);
        // Everything still in flight after a redirect is stale.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            disc_d     = out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (!rst)                                          fault_q <= 1'b0;
        else if (redirect && redirect_pc[1:0] != 2'b00)    fault_q <= 1'b1;
    end
    assign fault = fault_q;
`endif

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .clear    (redirect),
        .wr_instr (mem_rsp_data),
        .wr_pc    (rsp_pc_q),
        .rd_instr (head_instr),
        .rd_pc    (head_pc),
        .occupancy(occ)
    );

    assign mem_req_addr = fetch_pc_q;
    assign instr_valid  = (occ != '0);
    assign instr        = instr_valid ? head_instr : NOP_INSTR;
    assign instr_pc     = instr_valid ? head_pc : 32'h0;
    assign busy         = (out_q != '0) || (occ != '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory with programmable latency plus a stream-level model.
module tb_instr_fetch_unit;
    import rv_fetch_pkg::*;

    localparam int          MAXO = 2;
    localparam logic [31:0] KEY  = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst, enable, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic        instr_valid, instr_ready, busy;
    logic [31:0] redirect_pc, mem_req_addr, mem_rsp_data, instr, instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fault(fault),
`endif
        .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: accepted requests in order, each answered lat edges after acceptance.
    typedef struct { logic [31:0] addr; int edge_n; } req_t;
    req_t        q[$];
    int          lat = 1, edge_n = 0, fires = 0, pops = 0;
    logic [31:0] exp_pc = 0, req_exp = 0, prev_addr = 0, first_pc = 0;
    logic        prev_pend = 0, started = 0, rd_armed = 0;

    function automatic logic rsp_due();
        return (q.size() != 0) && (q[0].edge_n + lat <= edge_n);
    endfunction

    always @(negedge clk) begin
        #1;
        mem_rsp_valid = rst && rsp_due();
        mem_rsp_data  = mem_rsp_valid ? (q[0].addr ^ KEY) : 32'hDEADBEEF;
        #1;
        if (!rst) begin
            q.delete();
            exp_pc = 32'h0; req_exp = 32'h0; prev_pend = 0; rd_armed = 0; started = 1;
        end else if (started) begin
            if (!instr_valid) begin
                chk("empty_instr", instr, NOP_INSTR);
                chk("empty_pc", instr_pc, 32'h0);
            end
            chk("busy", busy, (q.size() != 0) || instr_valid);
            if (prev_pend) begin
                chk("hold_valid", mem_req_valid, 1);
                chk("hold_addr", mem_req_addr, prev_addr);
            end
            if (mem_req_valid) begin
                chk("req_addr", mem_req_addr, req_exp);
                chk("req_gate", q.size() < MAXO, 1);
            end
            if (mem_rsp_valid) void'(q.pop_front());
            if (instr_valid && instr_ready && !redirect) begin
                chk("pop_pc", instr_pc, exp_pc);
                chk("pop_instr", instr, exp_pc ^ KEY);
                if (rd_armed) begin first_pc = instr_pc; rd_armed = 0; end
                exp_pc += 4;
                pops++;
            end
            if (mem_req_valid && mem_req_ready) begin
                q.push_back('{mem_req_addr, edge_n});
                req_exp += 4;
                fires++;
            end
            prev_pend = mem_req_valid && !mem_req_ready && !redirect;
            prev_addr = mem_req_addr;
            if (redirect) begin exp_pc = redirect_pc; req_exp = redirect_pc; rd_armed = 1; end
        end
        edge_n++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int f0, p0;
    logic hit;

    initial begin
        rst = 0; enable = 0; redirect = 0; redirect_pc = 0;
        mem_req_ready = 1; instr_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0;
        cyc(3);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 32'h00000013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_busy", busy, 0);

        // Startup latency and back-to-back delivery.
        rst = 1; enable = 1;
        cyc(1); chk("lat_v0", instr_valid, 0); chk("lat_req0", mem_req_valid, 1);
        cyc(1); chk("lat_v1", instr_valid, 0);
        cyc(1); chk("seq0_pc", instr_pc, 32'h0); chk("seq0_instr", instr, 32'hA5A50000);
        cyc(1); chk("seq1_pc", instr_pc, 32'h4);
        cyc(1); chk("seq2_pc", instr_pc, 32'h8);
        cyc(1); chk("seq3_pc", instr_pc, 32'hC); chk("seq3_instr", instr, 32'hA5A5000C);

        // Consumer stall: buffer fills to DEPTH, requests stop, then drains in order.
        instr_ready = 0;
        cyc(10);
        chk("stall_req_valid", mem_req_valid, 0);
        chk("stall_outstanding", q.size(), 0);
        chk("stall_head_pc", instr_pc, 32'hC);
        enable = 0; instr_ready = 1; p0 = pops;
        cyc(8);
        chk("stall_drained", pops - p0, 4);
        chk("drain_valid", instr_valid, 0);
        chk("drain_busy", busy, 0);

        // Memory back-pressure: address held, exactly one fire on release.
        enable = 1; mem_req_ready = 0;
        cyc(1);
        f0 = fires;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", mem_req_valid, 1);
            chk("bp_addr", mem_req_addr, 32'h1C);
            chk("bp_fires", fires - f0, 0);
            if (i < 4) cyc(1);
        end
        mem_req_ready = 1;
        cyc(1); chk("bp_single_fire", fires - f0, 1);

        // Slow memory with two requests in flight, redirect discards both.
        lat = 3; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin cyc(1); hit = (q.size() == 2); end
        chk("rd1_inflight_reached", hit, 1);
        redirect = 1; redirect_pc = 32'h100;
        cyc(1); redirect = 0;
        for (int i = 0; i < 30 && rd_armed; i++) cyc(1);
        chk("rd1_armed_cleared", rd_armed, 0);
        chk("rd1_first_pc", first_pc, 32'h100);

        // Redirect together with a pop and a response while nearly full.
        instr_ready = 0; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cyc(1);
            hit = (q.size() == 2) && rsp_due() && !mem_req_valid && instr_valid;
        end
        chk("rd2_setup_reached", hit, 1);
        redirect = 1; redirect_pc = 32'h200; instr_ready = 1; enable = 0;
        cyc(1); redirect = 0;
        chk("rd2_flushed", instr_valid, 0);
        chk("rd2_busy_stale", busy, 1);
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            chk("rd2_busy_hold", busy, 1);
            cyc(1);
        end
        chk("rd2_drained", q.size(), 0);
        chk("rd2_idle_busy", busy, 0);
        chk("rd2_no_stale", instr_valid, 0);
        enable = 1;
        for (int i = 0; i < 30 && rd_armed; i++) cyc(1);
        chk("rd2_first_pc", first_pc, 32'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect = 1; redirect_pc = 32'h102;
        cyc(1); redirect = 0;
        chk("mis_fault", fault, 1);
        for (int i = 0; i < 8; i++) begin
            chk("mis_no_req", mem_req_valid, 0);
            cyc(1);
        end
        chk("mis_drained", busy, 0);
        rst = 0;
        cyc(1); rst = 1;
        chk("mis_fault_cleared", fault, 0);
        cyc(2);
`endif

        lat = 1;
        cyc(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
